pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_field_reg.sv | 30 +++
 rtl/pipe_stage_reg.sv | 122 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline registers.
// Lane indices name the generic data words carried between stages.
package pipe_pkg;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    localparam int LANE_RS  = 0;
    localparam int LANE_RT  = 1;
    localparam int LANE_EXT = 2;
    localparam int LANE_ALU = 3;
    localparam int LANE_DM  = 4;

    localparam int DEFAULT_LANES = 5;

    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// One field of a pipeline register: reset > clear > enable-load.
// Clear writes a bubble value; a disabled enable holds the field.
module pipe_field_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RST_VAL;
        end else if (clr) begin
            r_q <= CLR_VAL;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall (hold) and flush (bubble).
// Define PIPE_REG_PERF_CNT_EN to add stall/bubble performance counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          WIDTH         = 32,
    parameter int          LANES         = DEFAULT_LANES,
    parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
    parameter int          FLUSH_KEEP_PC = 0,
    parameter int          CNT_W         = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_instr,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_instr,
`ifdef PIPE_REG_PERF_CNT_EN
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       bubble_cnt
`else
    output logic [LANES*WIDTH-1:0] out_data
`endif
);

    localparam logic KEEP_PC = (FLUSH_KEEP_PC != 0);

    logic w_en;
    logic w_clr;
    logic w_pc_clr;

    // Flush must write even while stalled, so it also enables the load.
    assign w_en     = ~stall | flush;
    assign w_clr    = flush;
    assign w_pc_clr = flush & ~KEEP_PC;

    pipe_field_reg #(
        .W      (32),
        .RST_VAL(RESET_PC),
        .CLR_VAL(RESET_PC)
    ) u_pc (
        .clk  (clk),
        .reset(reset),
        .en   (w_en),
        .clr  (w_pc_clr),
        .d    (in_pc),
        .q    (out_pc)
    );

    pipe_field_reg #(
        .W      (32),
        .RST_VAL(INSTR_NOP),
        .CLR_VAL(INSTR_NOP)
    ) u_instr (
        .clk  (clk),
        .reset(reset),
        .en   (w_en),
        .clr  (w_clr),
        .d    (in_instr),
        .q    (out_instr)
    );

    pipe_field_reg #(
        .W      (1),
        .RST_VAL(1'b0),
        .CLR_VAL(1'b0)
    ) u_valid (
        .clk  (clk),
        .reset(reset),
        .en   (w_en),
        .clr  (w_clr),
        .d    (in_valid),
        .q    (out_valid)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pipe_field_reg #(
            .W      (WIDTH),
            .RST_VAL('0),
            .CLR_VAL('0)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .en   (w_en),
            .clr  (w_clr),
            .d    (in_data[lane_lo(k, WIDTH) +: WIDTH]),
            .q    (out_data[lane_lo(k, WIDTH) +: WIDTH])
        );
    end

`ifdef PIPE_REG_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_stall_hit;

    assign w_stall_hit = stall & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall_hit) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (flush) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: two instances (bubble PC = reset PC / keep in_pc)
// checked every cycle against a behavioural model, plus directed literals.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int WIDTH = 32;
    localparam int LANES = 5;
    localparam int DW    = LANES * WIDTH;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_pc = '0;
    logic [31:0]   in_instr = '0;
    logic [DW-1:0] in_data = '0;

    logic          v0, v1;
    logic [31:0]   pc0, pc1, ins0, ins1;
    logic [DW-1:0] d0, d1;
    logic [CW-1:0] sc0, bc0, sc1, bc1;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic chk_en  = 1'b0;

    logic          e_valid;
    logic [31:0]   e_pc0, e_pc1, e_instr;
    logic [DW-1:0] e_data;
    logic [CW-1:0] e_sc, e_bc;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .WIDTH(WIDTH), .LANES(LANES), .RESET_PC(32'h0000_3000),
        .FLUSH_KEEP_PC(0), .CNT_W(CW)
    ) dut0 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_data(in_data), .out_valid(v0), .out_pc(pc0),
        .out_instr(ins0),
`ifdef PIPE_REG_PERF_CNT_EN
        .out_data(d0), .stall_cnt(sc0), .bubble_cnt(bc0)
`else
        .out_data(d0)
`endif
    );

    pipe_stage_reg #(
        .WIDTH(WIDTH), .LANES(LANES), .RESET_PC(32'h0000_3000),
        .FLUSH_KEEP_PC(1), .CNT_W(CW)
    ) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_data(in_data), .out_valid(v1), .out_pc(pc1),
        .out_instr(ins1),
`ifdef PIPE_REG_PERF_CNT_EN
        .out_data(d1), .stall_cnt(sc1), .bubble_cnt(bc1)
`else
        .out_data(d1)
`endif
    );

`ifndef PIPE_REG_PERF_CNT_EN
    assign sc0 = '0;
    assign bc0 = '0;
    assign sc1 = '0;
    assign bc1 = '0;
`endif

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: the register's contents after an edge, from the rules.
    task automatic model_step();
        if (reset) begin
            e_valid = 1'b0;
            e_pc0   = 32'h0000_3000;
            e_pc1   = 32'h0000_3000;
            e_instr = '0;
            e_data  = '0;
            e_sc    = '0;
            e_bc    = '0;
        end else if (flush) begin
            e_valid = 1'b0;
            e_pc0   = 32'h0000_3000;
            e_pc1   = in_pc;
            e_instr = '0;
            e_data  = '0;
            e_bc    = e_bc + 1'b1;
        end else if (stall) begin
            e_sc = e_sc + 1'b1;
        end else begin
            e_valid = in_valid;
            e_pc0   = in_pc;
            e_pc1   = in_pc;
            e_instr = in_instr;
            e_data  = in_data;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < LANES; i++) d[i*WIDTH +: WIDTH] = $urandom;
        return d;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid0", DW'(v0), DW'(e_valid));
            chk("valid1", DW'(v1), DW'(e_valid));
            chk("pc0", DW'(pc0), DW'(e_pc0));
            chk("pc1", DW'(pc1), DW'(e_pc1));
            chk("instr0", DW'(ins0), DW'(e_instr));
            chk("instr1", DW'(ins1), DW'(e_instr));
            chk("data0", d0, e_data);
            chk("data1", d1, e_data);
`ifdef PIPE_REG_PERF_CNT_EN
            chk("scnt0", DW'(sc0), DW'(e_sc));
            chk("bcnt0", DW'(bc0), DW'(e_bc));
            chk("scnt1", DW'(sc1), DW'(e_sc));
            chk("bcnt1", DW'(bc1), DW'(e_bc));
`endif
        end
    end

    initial begin
        logic [DW-1:0] ld;
        e_sc = '0;
        e_bc = '0;
        repeat (2) @(posedge clk);
        #2;

        reset    = 1'b1;
        in_pc    = 32'h0000_4000;
        in_valid = 1'b1;
        in_instr = 32'h1234_5678;
        in_data  = rnd_data();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("rst_pc", DW'(pc0), DW'(32'h0000_3000));
        chk("rst_instr", DW'(ins0), '0);
        chk("rst_valid", DW'(v0), '0);
        chk("rst_data", d0, '0);
`ifdef PIPE_REG_PERF_CNT_EN
        chk("rst_cnt", DW'({sc0, bc0}), '0);
`endif

        ld = '0;
        ld[LANE_ALU*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
        in_pc    = 32'h0000_3004;
        in_instr = 32'h2408_0005;
        in_data  = ld;
        in_valid = 1'b1;
        #1;
        chk("load_early", DW'(pc0), DW'(32'h0000_3000));
        tick();
        chk("load_pc", DW'(pc0), DW'(32'h0000_3004));
        chk("load_instr", DW'(ins0), DW'(32'h2408_0005));
        chk("load_lane3", DW'(d0[LANE_ALU*WIDTH +: WIDTH]),
            DW'(32'hDEAD_BEEF));
        chk("load_valid", DW'(v0), DW'(1'b1));

        in_pc = 32'h0000_3008;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pc    = 32'h0000_5000 + 32'(i * 4);
            in_instr = $urandom;
            tick();
        end
        chk("stall_pc", DW'(pc0), DW'(32'h0000_3008));
`ifdef PIPE_REG_PERF_CNT_EN
        chk("stall_cnt3", DW'(sc0), DW'(3));
`endif
        stall = 1'b0;
        in_pc = 32'h0000_3100;
        tick();
        chk("release_pc", DW'(pc0), DW'(32'h0000_3100));

        stall    = 1'b1;
        flush    = 1'b1;
        in_pc    = 32'h0000_300C;
        in_instr = 32'h2409_0001;
        in_valid = 1'b1;
        tick();
        chk("fl_valid", DW'(v0), '0);
        chk("fl_instr", DW'(ins0), '0);
        chk("fl_pc_rst", DW'(pc0), DW'(32'h0000_3000));
        chk("fl_pc_keep", DW'(pc1), DW'(32'h0000_300C));
`ifdef PIPE_REG_PERF_CNT_EN
        chk("fl_bcnt", DW'(bc0), DW'(1));
        chk("fl_scnt", DW'(sc0), DW'(3));
`endif
        stall = 1'b0;
        flush = 1'b0;

        in_pc = 32'h0000_3010;
        tick();
        stall = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rms_pc", DW'(pc0), DW'(32'h0000_3000));
        chk("rms_valid", DW'(v0), '0);
`ifdef PIPE_REG_PERF_CNT_EN
        chk("rms_cnt", DW'({sc0, bc0}), '0);
`endif

        for (int i = 0; i < 17; i++) begin
            in_pc = $urandom;
            tick();
        end
        chk("wrap_pc", DW'(pc0), DW'(32'h0000_3000));
`ifdef PIPE_REG_PERF_CNT_EN
        chk("wrap_scnt", DW'(sc0), DW'(1));
`endif
        stall = 1'b0;

        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 99) < 3);
            flush    = ($urandom_range(0, 99) < 10);
            stall    = ($urandom_range(0, 99) < 30);
            in_valid = $urandom_range(0, 1) == 1;
            in_pc    = $urandom;
            in_instr = $urandom;
            in_data  = rnd_data();
            tick();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
